// File: rtl/eight_queen_pkg.sv
// eight_queen_pkg: shared FSM state type, default sizes and column index type for the N-queens sequencer
package eight_queen_pkg;
  localparam int N_DEF = 8;
  localparam int CNT_W_DEF = 8;
  typedef logic [$clog2(N_DEF):0] col_t;
  typedef enum logic [2:0] {IDLE, INIT, TRY, REQ, PLACE, BACK, DONE} state_t;
endpackage

// File: rtl/eq_col_stack.sv
// eq_col_stack: per-row column register file (clk, rst_n sync active-low, one write port we/waddr/wdata, comb read raddr->rdata)
module eq_col_stack
  import eight_queen_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int W  = $clog2(N_DEF) + 1,
  parameter int AW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [N];
  always_ff @(posedge clk) begin
    if (!rst_n) mem <= '{default: '0};
    else if (we) mem[waddr] <= wdata;
  end
  assign rdata = mem[raddr];
endmodule

// File: rtl/eight_queen_ctrl.sv
// eight_queen_ctrl: backtracking N-queens search sequencer
//   clk, rst_n (sync active-low), start pulse
//   chk_req/chk_row/chk_col -> external conflict checker, chk_ack/chk_safe <- its answer
//   brd_clr, brd_we/brd_set/brd_row/brd_col -> board register writes
//   result (saturating solution count), done (held until next start), busy
//   EQ_FIRST_SOL_EN: stop at the first solution and leave it on the board
module eight_queen_ctrl
  import eight_queen_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int COL_W = $clog2(N) + 1,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             chk_req,
  output logic [COL_W-1:0] chk_row,
  output logic [COL_W-1:0] chk_col,
  input  logic             chk_ack,
  input  logic             chk_safe,
  output logic             brd_clr,
  output logic             brd_we,
  output logic             brd_set,
  output logic [COL_W-1:0] brd_row,
  output logic [COL_W-1:0] brd_col,
  output logic [CNT_W-1:0] result,
  output logic             done,
  output logic             busy
);
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam logic [COL_W-1:0] NC = COL_W'(N);
  localparam logic [COL_W-1:0] NL = COL_W'(N - 1);
  state_t state;
  logic [COL_W-1:0] row, col, top_col;
  // top_col is always the column stored for row-1, the row a backtrack returns to
  eq_col_stack #(.N(N), .W(COL_W), .AW(AW)) u_stack (
    .clk(clk),
    .rst_n(rst_n),
    .we(state == PLACE),
    .waddr(row[AW-1:0]),
    .wdata(col),
    .raddr(row[AW-1:0] - 1'b1),
    .rdata(top_col)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      row     <= '0;
      col     <= '0;
      chk_req <= 1'b0;
      chk_row <= '0;
      chk_col <= '0;
      brd_clr <= 1'b0;
      brd_we  <= 1'b0;
      brd_set <= 1'b0;
      brd_row <= '0;
      brd_col <= '0;
      result  <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      brd_clr <= 1'b0;
      brd_we  <= 1'b0;
      case (state)
        IDLE, DONE: if (start) begin
          state   <= INIT;
          done    <= 1'b0;
          busy    <= 1'b1;
          brd_clr <= 1'b1;
        end
        INIT: begin
          result <= '0;
          row    <= '0;
          col    <= '0;
          state  <= TRY;
        end
        // outputs are launched on entry so each write/request lines up with its state
        TRY: if (col == NC) begin
          state   <= BACK;
          brd_we  <= row != '0;
          brd_set <= 1'b0;
          brd_row <= row - 1'b1;
          brd_col <= top_col;
        end else begin
          state   <= REQ;
          chk_req <= 1'b1;
          chk_row <= row;
          chk_col <= col;
        end
        REQ: if (chk_ack) begin
          chk_req <= 1'b0;
          if (chk_safe) begin
            state   <= PLACE;
            brd_we  <= 1'b1;
`ifdef EQ_FIRST_SOL_EN
            brd_set <= 1'b1;
`else
            brd_set <= row != NL;
`endif
            brd_row <= row;
            brd_col <= col;
          end else begin
            col   <= col + 1'b1;
            state <= TRY;
          end
        end
        PLACE: if (row != NL) begin
          row   <= row + 1'b1;
          col   <= '0;
          state <= TRY;
        end else begin
`ifdef EQ_FIRST_SOL_EN
          result <= CNT_W'(1);
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= DONE;
`else
          result <= &result ? result : result + 1'b1;
          col    <= col + 1'b1;
          state  <= TRY;
`endif
        end
        BACK: if (row == '0) begin
          state <= DONE;
          done  <= 1'b1;
          busy  <= 1'b0;
        end else begin
          row   <= row - 1'b1;
          col   <= top_col + 1'b1;
          state <= TRY;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_eight_queen_ctrl.sv
// tb_eight_queen_ctrl: N-queens sequencer bench with board/checker model and random ack latency
module tb_eight_queen_ctrl;
  localparam int NI = 5;
  localparam int NS [NI] = '{8, 4, 1, 3, 6};
  localparam int CS [NI] = '{8, 8, 8, 8, 2};
  localparam int LIM = 70000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  int checks = 0;
  int errors = 0;
  int res_v [NI];
  logic done_v [NI];
  logic busy_v [NI];
  logic req_v [NI];
  int perr_v [NI];
  int clr_v [NI];
  int brd_v [NI][16];
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit attacked(input int b [16], input int r, input int c);
    for (int i = 0; i < r; i++)
      if (b[i] >= 0 && (b[i] == c || b[i] - c == r - i || c - b[i] == r - i)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int count_sol(input int n);
    int q [16];
    int r = 0;
    int cnt = 0;
    for (int i = 0; i < 16; i++) q[i] = -1;
    while (r >= 0) begin
      q[r]++;
      while (q[r] < n && attacked(q, r, q[r])) q[r]++;
      if (q[r] >= n) begin
        q[r] = -1;
        r--;
      end else if (r == n - 1) cnt++;
      else r++;
    end
    return cnt;
  endfunction

  function automatic bit all_done(input int from);
    for (int i = from; i < NI; i++) if (!done_v[i]) return 1'b0;
    return 1'b1;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int N = NS[g];
    localparam int CW = $clog2(N) + 1;
    localparam int KW = CS[g];
    logic req, clr, we, set, done, busy;
    logic ack = 1'b0;
    logic safe = 1'b0;
    logic [CW-1:0] crow, ccol, brow, bcol, lrow, lcol;
    logic [KW-1:0] res;
    int board [16];
    int cnt = 0;
    int dly = 0;
    int perr = 0;
    int nclr = 0;
    eight_queen_ctrl #(.N(N), .COL_W(CW), .CNT_W(KW)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(g == 0 ? start_a : start_b),
      .chk_req(req),
      .chk_row(crow),
      .chk_col(ccol),
      .chk_ack(ack),
      .chk_safe(safe),
      .brd_clr(clr),
      .brd_we(we),
      .brd_set(set),
      .brd_row(brow),
      .brd_col(bcol),
      .result(res),
      .done(done),
      .busy(busy)
    );
    initial for (int r = 0; r < 16; r++) board[r] = -1;
    always @(posedge clk) begin
      if (clr) begin
        for (int r = 0; r < 16; r++) board[r] = -1;
        nclr++;
      end
      if (we) board[brow] = set ? int'(bcol) : -1;
      if (clr && we) perr++;
      if (req && (done || !busy)) perr++;
      if (req && int'(ccol) >= N) perr++;
    end
    always @(negedge clk) begin
      if (!req) begin
        ack = 1'b0;
        cnt = 0;
        dly = (g == 0) ? (($urandom % 8 == 0) ? int'($urandom_range(1, 5)) : 0) : int'($urandom_range(0, 5));
      end else begin
        if (cnt > 0 && (crow != lrow || ccol != lcol)) perr++;
        lrow = crow;
        lcol = ccol;
        ack = cnt >= dly;
        safe = !attacked(board, int'(crow), int'(ccol));
        cnt++;
      end
    end
    assign res_v[g] = int'(res);
    assign done_v[g] = done;
    assign busy_v[g] = busy;
    assign req_v[g] = req;
    assign perr_v[g] = perr;
    assign clr_v[g] = nclr;
    assign brd_v[g] = board;
  end

  initial begin
    int exp_res [NI];
    int pclr [NI];
    int sol8 [8];
    int k, q, c, first;
    sol8 = '{0, 4, 7, 5, 2, 6, 1, 3};
`ifdef EQ_FIRST_SOL_EN
    first = 1;
`else
    first = 0;
`endif
    for (int i = 0; i < NI; i++) begin
      c = count_sol(NS[i]);
      exp_res[i] = first ? int'(c > 0) : (c > (1 << CS[i]) - 1 ? (1 << CS[i]) - 1 : c);
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst_result%0d", i), res_v[i], 0);
      check($sformatf("rst_done%0d", i), int'(done_v[i]), 0);
      check($sformatf("rst_busy%0d", i), int'(busy_v[i]), 0);
      check($sformatf("rst_req%0d", i), int'(req_v[i]), 0);
    end
    rst_n = 1'b1;
    start_a = 1'b1;
    start_b = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    repeat (300) @(negedge clk);
    check("busy_mid", int'(busy_v[0]), 1);
    pclr[0] = clr_v[0];
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (3) @(negedge clk);
    check("start_ignored_clr", clr_v[0], pclr[0]);
    check("start_ignored_busy", int'(busy_v[0]), 1);
    rst_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("midrst_busy%0d", i), int'(busy_v[i]), 0);
      check($sformatf("midrst_done%0d", i), int'(done_v[i]), 0);
      check($sformatf("midrst_result%0d", i), res_v[i], 0);
      check($sformatf("midrst_req%0d", i), int'(req_v[i]), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    start_a = 1'b1;
    start_b = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    repeat (50) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    k = 0;
    while (!all_done(0) && k < LIM) begin
      @(negedge clk);
      k++;
    end
    check("done_in_time", int'(k < LIM), 1);
    repeat (20) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("result_n%0d", NS[i]), res_v[i], exp_res[i]);
      check($sformatf("done_n%0d", NS[i]), int'(done_v[i]), 1);
      check($sformatf("busy_n%0d", NS[i]), int'(busy_v[i]), 0);
      check($sformatf("protocol_n%0d", NS[i]), perr_v[i], 0);
      q = 0;
      for (int r = 0; r < 16; r++) if (brd_v[i][r] >= 0) q++;
      check($sformatf("queens_n%0d", NS[i]), q, (first && exp_res[i] > 0) ? NS[i] : 0);
    end
    if (first) for (int r = 0; r < 8; r++) check($sformatf("first_sol_row%0d", r), brd_v[0][r], sol8[r]);
    for (int i = 0; i < NI; i++) pclr[i] = clr_v[i];
    start_a = 1'b1;
    start_b = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    for (int i = 0; i < NI; i++) check($sformatf("restart_done%0d", i), int'(done_v[i]), 0);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("restart_clr%0d", i), clr_v[i], pclr[i] + 1);
      check($sformatf("restart_result%0d", i), res_v[i], 0);
    end
    k = 0;
    while (!all_done(1) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check("redone_in_time", int'(k < 5000), 1);
    for (int i = 1; i < NI; i++) check($sformatf("rerun_result_n%0d", NS[i]), res_v[i], exp_res[i]);
    for (int i = 0; i < NI; i++) check($sformatf("final_protocol%0d", i), perr_v[i], 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
